// File: rtl/axi64_slave_mem.sv
// AXI3-style 64-bit slave memory with independent write (AW/W/B) and read (AR/R) engines
// sharing one byte-strobed word array. INCR bursts only; out-of-range beats answer SLVERR.
module axi64_slave_mem #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [1:0]        AWSIZE,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ID_W-1:0]   WID,
    input  logic [63:0]       WDATA,
    input  logic [7:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [1:0]        ARSIZE,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [63:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    // Underflow below BASE_ADDR shows up as the borrow bit of the extended subtraction.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] d;
        d = {1'b0, a} - {1'b0, BASE_ADDR};
        return !d[ADDR_W] && (d[ADDR_W-1:IDX_W+3] == '0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] d;
        d = a - BASE_ADDR;
        return d[IDX_W+2:3];
    endfunction

    logic [63:0]       r_mem [MEM_WORDS];

    w_state_t          r_w_state;
    logic [ID_W-1:0]   r_aw_id;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [3:0]        r_aw_len;
    logic [1:0]        r_aw_size;
    logic [3:0]        r_w_cnt;
    logic              r_w_err;

    r_state_t          r_r_state;
    logic [ID_W-1:0]   r_ar_id;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [3:0]        r_ar_len;
    logic [1:0]        r_ar_size;
    logic [3:0]        r_r_cnt;
    logic [LAT_W-1:0]  r_lat_cnt;

    logic              w_w_hs, w_w_last, w_w_bad, w_wr_ok;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_r_load, w_rd_ok;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [63:0]       w_rd_word;

    always_comb begin
        w_wr_ok   = addr_ok(r_aw_addr);
        w_wr_idx  = addr_idx(r_aw_addr);
        w_w_hs    = (r_w_state == W_DATA) && WVALID && WREADY;
        w_w_last  = (r_w_cnt == r_aw_len);
        w_w_bad   = (WLAST != w_w_last) || (WID != r_aw_id) || !w_wr_ok;
        w_rd_ok   = addr_ok(r_ar_addr);
        w_rd_idx  = addr_idx(r_ar_addr);
        w_rd_word = w_rd_ok ? r_mem[w_rd_idx] : 64'd0;
        w_r_load  = ((r_r_state == R_WAIT) && (r_lat_cnt == '0)) ||
                    ((r_r_state == R_DATA) && RREADY && !RLAST);
    end

    // NOTE: the word array has no reset so buffer contents survive a reset of the engines.
    always_ff @(posedge clk) begin
        if (w_w_hs && w_wr_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (WSTRB[b]) r_mem[w_wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_w_state <= W_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= 2'b00;
            r_aw_id   <= '0;
            r_aw_addr <= '0;
            r_aw_len  <= '0;
            r_aw_size <= '0;
            r_w_cnt   <= '0;
            r_w_err   <= 1'b0;
        end else begin
            unique case (r_w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        r_aw_id   <= AWID;
                        r_aw_addr <= AWADDR;
                        r_aw_len  <= AWLEN;
                        r_aw_size <= AWSIZE;
                        r_w_cnt   <= '0;
                        r_w_err   <= 1'b0;
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b1;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_aw_addr <= r_aw_addr + (ADDR_W'(1) << r_aw_size);
                        r_w_cnt   <= r_w_cnt + 4'd1;
                        r_w_err   <= r_w_err | w_w_bad;
                        // AWLEN alone ends the burst; a misplaced WLAST only flags the error.
                        if (w_w_last) begin
                            WREADY    <= 1'b0;
                            BVALID    <= 1'b1;
                            BID       <= r_aw_id;
                            BRESP     <= (r_w_err || w_w_bad) ? 2'b10 : 2'b00;
                            r_w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID    <= 1'b0;
                        r_w_err   <= 1'b0;
                        AWREADY   <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_r_state <= R_IDLE;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RID       <= '0;
            RDATA     <= '0;
            RRESP     <= 2'b00;
            RLAST     <= 1'b0;
            r_ar_id   <= '0;
            r_ar_addr <= '0;
            r_ar_len  <= '0;
            r_ar_size <= '0;
            r_r_cnt   <= '0;
            r_lat_cnt <= '0;
        end else begin
            unique case (r_r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        r_ar_id   <= ARID;
                        r_ar_addr <= ARADDR;
                        r_ar_len  <= ARLEN;
                        r_ar_size <= ARSIZE;
                        r_r_cnt   <= '0;
                        r_lat_cnt <= LAT_W'(RD_LAT - 1);
                        ARREADY   <= 1'b0;
                        r_r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_lat_cnt == '0) r_r_state <= R_DATA;
                    else                 r_lat_cnt <= r_lat_cnt - 1'b1;
                end
                R_DATA: begin
                    if (RREADY && RLAST) begin
                        RVALID    <= 1'b0;
                        RLAST     <= 1'b0;
                        ARREADY   <= 1'b1;
                        r_r_state <= R_IDLE;
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
            // Beat load reads the array before any same-edge write lands.
            if (w_r_load) begin
                RVALID    <= 1'b1;
                RID       <= r_ar_id;
                RDATA     <= w_rd_word;
                RRESP     <= w_rd_ok ? 2'b00 : 2'b10;
                RLAST     <= (r_r_cnt == r_ar_len);
                r_ar_addr <= r_ar_addr + (ADDR_W'(1) << r_ar_size);
                r_r_cnt   <= r_r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi64_slave_mem.sv
// Directed bench for axi64_slave_mem (RD_LAT=3): bursts, strobes, narrow size,
// end-of-memory errors, WLAST misuse, read stall and mid-burst reset.
module tb_axi64_slave_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [3:0]  AWLEN, ARLEN;
    logic [1:0]  AWSIZE, ARSIZE, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] wr_data [16];
    logic [7:0]  wr_strb [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [3:0]  bid;
    logic [1:0]  bresp;
    int          lat;
    int          guard;

    axi64_slave_mem #(.RD_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] size, input int last_beat);
        int g;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        g = 0;
        while (!AWREADY && g < 50) begin @(negedge clk); g++; end
        chk("awready", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WID = id; WDATA = wr_data[i]; WSTRB = wr_strb[i];
            WLAST = (i == last_beat); WVALID = 1'b1;
            g = 0;
            while (!WREADY && g < 50) begin @(negedge clk); g++; end
            chk("wready", WREADY, 1);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        g = 0;
        while (!BVALID && g < 50) begin @(negedge clk); g++; end
        chk("bvalid", BVALID, 1);
        bid = BID; bresp = BRESP;
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] size, input int stall);
        int g;
        logic [63:0] s_data;
        logic        s_last;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1; RREADY = 1'b0;
        g = 0;
        while (!ARREADY && g < 50) begin @(negedge clk); g++; end
        chk("arready", ARREADY, 1);
        @(negedge clk);
        ARVALID = 1'b0;
        lat = 0;
        while (!RVALID && lat < 50) begin @(negedge clk); lat++; end
        s_data = RDATA; s_last = RLAST;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_rvalid", RVALID, 1);
            chk("stall_rdata", RDATA, s_data);
            chk("stall_rlast", RLAST, s_last);
        end
        RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            chk("rvalid", RVALID, 1);
            rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id[i] = RID;
            @(negedge clk);
        end
        RREADY = 1'b0;
        chk("rvalid_end", RVALID, 0);
    endtask

    initial begin
        reset = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        reset = 1'b1;
        @(negedge clk);

        // 4-beat full-width burst, written then read back
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 64'h0123_4567_89AB_CDE0 + 64'(i);
            wr_strb[i] = 8'hFF;
        end
        do_write(4'd3, 32'h40, 4'd3, 2'd3, 3);
        chk("t1_bid", bid, 3);
        chk("t1_bresp", bresp, 0);
        do_read(4'd5, 32'h40, 4'd3, 2'd3, 0);
        chk("t1_lat", lat, 3);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rdata", rd_data[i], 64'h0123_4567_89AB_CDE0 + 64'(i));
            chk("t1_rresp", rd_resp[i], 0);
            chk("t1_rlast", rd_last[i], (i == 3) ? 1 : 0);
            chk("t1_rid", rd_id[i], 5);
        end

        // Partial strobe onto a zeroed word
        wr_data[0] = 64'd0; wr_strb[0] = 8'hFF;
        do_write(4'd1, 32'h0, 4'd0, 2'd3, 0);
        chk("t2_clear_bresp", bresp, 0);
        wr_data[0] = 64'h1122_3344_5566_7788; wr_strb[0] = 8'h0F;
        do_write(4'd1, 32'h0, 4'd0, 2'd3, 0);
        chk("t2_bresp", bresp, 0);
        do_read(4'd2, 32'h0, 4'd0, 2'd3, 0);
        chk("t2_rdata", rd_data[0], 64'h0000_0000_5566_7788);
        chk("t2_rlast", rd_last[0], 1);

        // Read stalled 5 cycles with RREADY low
        do_read(4'd6, 32'h40, 4'd3, 2'd3, 5);
        chk("t3_lat", lat, 3);
        chk("t3_rdata0", rd_data[0], 64'h0123_4567_89AB_CDE0);
        chk("t3_rdata3", rd_data[3], 64'h0123_4567_89AB_CDE3);
        chk("t3_rlast3", rd_last[3], 1);

        // Narrow 4-byte beats fill the two halves of one word
        wr_data[0] = 64'hFFFF_FFFF_AAAA_1111; wr_strb[0] = 8'h0F;
        wr_data[1] = 64'hBBBB_2222_FFFF_FFFF; wr_strb[1] = 8'hF0;
        do_write(4'd2, 32'h100, 4'd1, 2'd2, 1);
        chk("nar_bresp", bresp, 0);
        do_read(4'd2, 32'h100, 4'd1, 2'd2, 0);
        chk("nar_rdata0", rd_data[0], 64'hBBBB_2222_AAAA_1111);
        chk("nar_rdata1", rd_data[1], 64'hBBBB_2222_AAAA_1111);
        chk("nar_rlast0", rd_last[0], 0);
        chk("nar_rlast1", rd_last[1], 1);

        // Burst crossing the top of memory
        wr_data[0] = 64'hDEAD_BEEF_0000_0001; wr_strb[0] = 8'hFF;
        wr_data[1] = 64'hDEAD_BEEF_0000_0002; wr_strb[1] = 8'hFF;
        do_write(4'd4, 32'h1FF8, 4'd1, 2'd3, 1);
        chk("t4_bid", bid, 4);
        chk("t4_bresp", bresp, 2'b10);
        do_read(4'd4, 32'h1FF8, 4'd1, 2'd3, 0);
        chk("t4_rdata0", rd_data[0], 64'hDEAD_BEEF_0000_0001);
        chk("t4_rresp0", rd_resp[0], 2'b00);
        chk("t4_rdata1", rd_data[1], 64'd0);
        chk("t4_rresp1", rd_resp[1], 2'b10);
        chk("t4_rlast1", rd_last[1], 1);
        do_read(4'd4, 32'h0, 4'd0, 2'd3, 0);
        chk("t4_word0_intact", rd_data[0], 64'h0000_0000_5566_7788);

        // Early WLAST: all four beats still taken, error reported
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 64'hC0C0_0000_0000_0000 + 64'(i);
            wr_strb[i] = 8'hFF;
        end
        do_write(4'd7, 32'h200, 4'd3, 2'd3, 1);
        chk("t5_bid", bid, 7);
        chk("t5_bresp", bresp, 2'b10);

        // Reset while beat 2 of a read is presented
        ARID = 4'd9; ARADDR = 32'h40; ARLEN = 4'd3; ARSIZE = 2'd3; ARVALID = 1'b1;
        guard = 0;
        while (!ARREADY && guard < 50) begin @(negedge clk); guard++; end
        chk("t6_arready", ARREADY, 1);
        @(negedge clk);
        ARVALID = 1'b0;
        RREADY = 1'b1;
        guard = 0;
        while (!RVALID && guard < 50) begin @(negedge clk); guard++; end
        chk("t6_rvalid", RVALID, 1);
        repeat (2) @(negedge clk);
        chk("t6_beat2", RDATA, 64'h0123_4567_89AB_CDE2);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_rvalid", RVALID, 0);
        chk("t6_rst_rlast", RLAST, 0);
        chk("t6_rst_arready", ARREADY, 0);
        reset = 1'b1;
        RREADY = 1'b0;
        @(negedge clk);
        do_read(4'd9, 32'h48, 4'd0, 2'd3, 0);
        chk("t6_lat", lat, 3);
        chk("t6_rdata", rd_data[0], 64'h0123_4567_89AB_CDE1);
        chk("t6_rid", rd_id[0], 9);
        chk("t6_rresp", rd_resp[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
